// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump block: state encoding and
// default geometry matching the CPU register file.
package regfile_dump_pkg;

   // Default register-file geometry (shared with the register-file parameters)
   localparam int unsigned NREG_DEF = 32;
   localparam int unsigned AW_DEF   = 5;
   localparam int unsigned DW_DEF   = 32;

   // Dump sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Any state other than IDLE means a dump is in flight
   function automatic logic state_busy(input state_t s);
      return (s != ST_IDLE);
   endfunction

endpackage : regfile_dump_pkg

// File: rtl/regfile_dump.sv
// Sequential reader for the CPU register file: walks addresses 0..NREG-1
// through one read port and streams (index, data) pairs over valid/ready.
module regfile_dump
   import regfile_dump_pkg::*;
#(
   parameter int unsigned NREG = NREG_DEF,
   parameter int unsigned AW   = AW_DEF,
   parameter int unsigned DW   = DW_DEF
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          start,
   input  logic          abort,
   output logic [AW-1:0] rn,
   input  logic [DW-1:0] rdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_idx,
   output logic [DW-1:0] out_data,
   output logic          busy,
   output logic          done
);

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] idx;
   logic          last;
   logic          accept;

   // Index of the final register; idx never advances beyond it
   assign last   = (idx == AW'(NREG - 1));
   // A word is delivered only when the consumer takes it and no abort wins
   assign accept = out_valid & out_ready & ~abort;

   // State register
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; abort beats a simultaneous handshake
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_nxt = abort ? ST_IDLE : ST_SEND;
         end
         ST_SEND: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (out_valid && out_ready) begin
               state_nxt = last ? ST_DONE : ST_FETCH;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Decoded outputs: read address only driven while fetching
   always_comb begin
      rn   = '0;
      busy = state_busy(state);
      done = 1'b0;
      case (state)
         ST_FETCH: rn   = idx;
         ST_DONE:  done = 1'b1;
         default:  rn   = '0;
      endcase
   end

   // Index counter and captured output word
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         idx       <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  idx <= '0;
               end
            end
            ST_FETCH: begin
               if (abort) begin
                  idx       <= '0;
                  out_valid <= 1'b0;
               end else begin
                  out_data  <= rdata;
                  out_idx   <= idx;
                  out_valid <= 1'b1;
               end
            end
            ST_SEND: begin
               if (abort) begin
                  idx       <= '0;
                  out_valid <= 1'b0;
               end else if (accept) begin
                  out_valid <= 1'b0;
                  if (!last) begin
                     idx <= idx + AW'(1);
                  end
               end
            end
            ST_DONE: begin
               idx <= '0;
            end
            default: begin
               idx       <= '0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule : regfile_dump
